// File: rtl/ascii_bcd_stream.sv
// ============================================================================
// Module   : ascii_bcd_stream
// Brief    : Packs a stream of ASCII digits into DIGITS-wide packed-BCD words,
//            ending a word early on a terminator and flagging invalid chars.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ascii_bcd_stream #(
    parameter int          DIGITS = 4,
    parameter logic [7:0]  TERM   = 8'h0D,
    parameter int          CW     = $clog2(DIGITS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            in_char,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic [CW-1:0]         out_count,
    output logic                  out_err,
    output logic                  out_valid,
    input  logic                  out_ready
);

    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_HOLD    = 1'b1
    } state_t;

    localparam logic [CW-1:0] c_last_count = CW'(DIGITS - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [4*DIGITS-1:0]  r_bcd;
    logic [4*DIGITS-1:0]  w_bcd_nxt;
    logic [4*DIGITS-1:0]  w_bcd_shift;
    logic [CW-1:0]        r_count;
    logic [CW-1:0]        w_count_nxt;
    logic                 r_err;
    logic                 w_err_nxt;
    logic                 w_accept;
    logic                 w_is_digit;
    logic                 w_is_term;

    assign w_is_digit = (in_char >= 8'h30) && (in_char <= 8'h39);
    assign w_is_term  = (in_char == TERM);

    // in_ready is masked by rst so nothing is offered as accepted during reset
    assign in_ready  = (r_state == ST_COLLECT) && !rst;
    assign out_valid = (r_state == ST_HOLD);
    assign w_accept  = in_valid && in_ready;

    assign out_bcd   = r_bcd;
    assign out_count = r_count;
    assign out_err   = r_err;

    generate
        if (DIGITS > 1) begin : g_shift_multi
            assign w_bcd_shift = {r_bcd[4*DIGITS-5:0], in_char[3:0]};
        end else begin : g_shift_single
            assign w_bcd_shift = in_char[3:0];
        end
    endgenerate

    always_comb begin
        w_state_nxt = r_state;
        w_bcd_nxt   = r_bcd;
        w_count_nxt = r_count;
        w_err_nxt   = r_err;
        case (r_state)
            ST_COLLECT: begin
                if (w_accept) begin
                    if (w_is_digit) begin
                        w_bcd_nxt   = w_bcd_shift;
                        w_count_nxt = r_count + 1'b1;
                        if (r_count == c_last_count) begin
                            w_state_nxt = ST_HOLD;
                        end
                    end else if (w_is_term) begin
                        w_state_nxt = ST_HOLD;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    w_bcd_nxt   = '0;
                    w_count_nxt = '0;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = ST_COLLECT;
                end
            end
            default: begin
                w_state_nxt = ST_COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_COLLECT;
            r_bcd   <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_bcd   <= w_bcd_nxt;
            r_count <= w_count_nxt;
            r_err   <= w_err_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ascii_bcd_stream.sv
// ============================================================================
// Module   : tb_ascii_bcd_stream
// Brief    : Directed bench for ascii_bcd_stream with a queue-based word model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ascii_bcd_stream;

    localparam int         DIGITS = 4;
    localparam logic [7:0] TERM   = 8'h0D;
    localparam int         CW     = $clog2(DIGITS + 1);

    logic                 clk;
    logic                 rst;
    logic [7:0]           in_char;
    logic                 in_valid;
    logic                 in_ready;
    logic [4*DIGITS-1:0]  out_bcd;
    logic [CW-1:0]        out_count;
    logic                 out_err;
    logic                 out_valid;
    logic                 out_ready;

    int total = 0;
    int bad   = 0;
    bit run_chk = 0;

    ascii_bcd_stream #(.DIGITS(DIGITS), .TERM(TERM)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_char   (in_char),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_bcd   (out_bcd),
        .out_count (out_count),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Word model: digits held as a queue, word emitted when full or terminated
    bit   m_hold;
    int   m_digits[$];
    bit   m_err;

    function automatic logic [31:0] m_bcd();
        logic [31:0] v = 0;
        foreach (m_digits[i]) v = (v << 4) | 32'(m_digits[i]);
        return v;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_hold = 0;
            m_digits.delete();
            m_err = 0;
        end else if (!m_hold) begin
            if (in_valid) begin
                if (in_char >= "0" && in_char <= "9") begin
                    m_digits.push_back(int'(in_char) - 48);
                    if (m_digits.size() == DIGITS) m_hold = 1;
                end else if (in_char == TERM) begin
                    m_hold = 1;
                end else begin
                    m_err = 1;
                end
            end
        end else if (out_ready) begin
            m_hold = 0;
            m_digits.delete();
            m_err = 0;
        end
    end

    always @(negedge clk) begin
        if (run_chk) begin
            chk("m_in_ready",  32'(in_ready),  32'(!m_hold && !rst));
            chk("m_out_valid", 32'(out_valid), 32'(m_hold));
            chk("m_out_bcd",   32'(out_bcd),   m_bcd());
            chk("m_out_count", 32'(out_count), 32'(m_digits.size()));
            chk("m_out_err",   32'(out_err),   32'(m_err));
        end
    end

    task automatic send(input logic [7:0] c);
        int   n = 0;
        logic acc;
        in_char  = c;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            acc = in_ready && !rst;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 50);
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL send_timeout: char %0h never accepted", c);
        end
        in_valid = 1'b0;
    endtask

    task automatic expect_word(input string name, input logic [15:0] bcd,
                               input int cnt, input bit err, input int lat);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 50);
        if (!out_valid) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: out_valid never rose", name);
        end
        chk({name, "_bcd"},   32'(out_bcd),   32'(bcd));
        chk({name, "_count"}, 32'(out_count), 32'(cnt));
        chk({name, "_err"},   32'(out_err),   32'(err));
        if (lat > 0) chk({name, "_latency"}, 32'(n), 32'(lat));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_char = 8'h00; in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        run_chk = 1;
        @(negedge clk);
        chk("reset_in_ready",  32'(in_ready),  32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_bcd",       32'(out_bcd),   32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: full word, immediate consumer, one-cycle out_valid
        send("1"); send("2"); send("3"); send("4");
        expect_word("t1", 16'h1234, 4, 1'b0, 1);
        @(negedge clk);
        chk("t1_valid_drop", 32'(out_valid), 32'd0);
        @(posedge clk); #1;

        // 2: stalled consumer with a pending '9' that must not be lost or absorbed
        out_ready = 1'b0;
        send("8"); send("8"); send("8"); send("8");
        in_char = "9"; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t2_in_ready", 32'(in_ready), 32'd0);
            chk("t2_bcd",      32'(out_bcd),  32'h8888);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        send("9"); send(TERM);
        expect_word("t2b", 16'h0009, 1, 1'b0, 0);

        // 3: bad char then short terminated word
        send(8'h73); send("1"); send("2"); send(TERM);
        expect_word("t3", 16'h0012, 2, 1'b1, 1);

        // 4: bare terminator
        send(TERM);
        expect_word("t4", 16'h0000, 0, 1'b0, 1);

        // 5: mid-word reset discards residue
        send("9"); send("8");
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        send("7"); send("6"); send("5"); send("4");
        expect_word("t5", 16'h7654, 4, 1'b0, 1);

        // 6: high-bit and just-past-'9' characters rejected
        send(8'hB8); send(8'h3A);
        send("5"); send("5"); send("5"); send("5");
        expect_word("t6", 16'h5555, 4, 1'b1, 1);

        repeat (3) @(posedge clk);
        run_chk = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
